// File: rtl/wb_test_responder_if.sv
// Wishbone classic slave-side bus bundle for wb_test_responder.
// The master modport drives the request, the slave modport returns ack and read data.
interface wb_test_responder_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_test_responder.sv
// Wishbone test responder: ID/STATUS/SCRATCH/COUNT registers plus a 16-word RAM, STATUS shown on pads.
// Define WB_RESP_TXN_CNT_EN to add the read-only TXN completed-transaction counter at offset 0x10.
module wb_test_responder #(
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
    parameter logic [31:0] ID_VALUE    = 32'hCA5E_0001,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    wb_test_responder_if.slave  wbs,
    output logic [37:0]         io_out,
    output logic [37:0]         io_oeb
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        req, hit, commit, wr;
    logic [5:0]  word;
    logic        is_ram;
    logic [3:0]  ram_idx;
    logic [7:0]  status_q;
    logic [31:0] scratch_q;
    logic [31:0] count_q;
    logic [31:0] reg_rd, reg_rd_q;
    logic [31:0] ram_rd;
    logic        rd_ram_q;
    logic        unused_adr;

    assign req     = wbs.wbs_stb_i & wbs.wbs_cyc_i;
    assign hit     = (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign word    = wbs.wbs_adr_i[7:2];
    assign is_ram  = (word[5:4] == 2'b01);
    assign ram_idx = word[3:0];
    assign wr      = commit & wbs.wbs_we_i;
    assign unused_adr = &{1'b0, wbs.wbs_adr_i[1:0]};

    // commit marks the cycle whose closing edge enters ACK; writes land on that edge.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && hit) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wait_d  = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (wait_q == 4'd0) begin
                    state_d = ST_ACK;
                    commit  = 1'b1;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            status_q <= 8'd0;
        end else if (wr && word == 6'd1 && wbs.wbs_sel_i[0]) begin
            status_q <= wbs.wbs_dat_i[7:0];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            count_q <= 32'd0;
        end else if (wr && word == 6'd3) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_q + 32'd1;
        end
    end

`ifdef WB_RESP_TXN_CNT_EN
    logic [15:0] txn_w_q, txn_r_q;

    // A write to TXN clears both fields and is not itself counted.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            txn_w_q <= 16'd0;
            txn_r_q <= 16'd0;
        end else if (commit) begin
            if (wbs.wbs_we_i && word == 6'd4) begin
                txn_w_q <= 16'd0;
                txn_r_q <= 16'd0;
            end else if (wbs.wbs_we_i) begin
                if (txn_w_q != 16'hFFFF) txn_w_q <= txn_w_q + 16'd1;
            end else begin
                if (txn_r_q != 16'hFFFF) txn_r_q <= txn_r_q + 16'd1;
            end
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] scratch_byte_q;
            logic [7:0] ram_lane [16];
            logic [7:0] ram_rd_q;

            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    scratch_byte_q <= 8'd0;
                end else if (wr && word == 6'd2 && wbs.wbs_sel_i[gi]) begin
                    scratch_byte_q <= wbs.wbs_dat_i[8*gi +: 8];
                end
            end

            // RAM lane with registered read; contents are not reset.
            always_ff @(posedge wb_clk_i) begin
                if (wr && is_ram && wbs.wbs_sel_i[gi]) begin
                    ram_lane[ram_idx] <= wbs.wbs_dat_i[8*gi +: 8];
                end
                if (commit) begin
                    ram_rd_q <= ram_lane[ram_idx];
                end
            end

            assign scratch_q[8*gi +: 8] = scratch_byte_q;
            assign ram_rd[8*gi +: 8]    = ram_rd_q;
        end
    endgenerate

    always_comb begin
        reg_rd = 32'hDEAD_BEEF;
        case (word)
            6'd0: reg_rd = ID_VALUE;
            6'd1: reg_rd = {24'd0, status_q};
            6'd2: reg_rd = scratch_q;
            6'd3: reg_rd = count_q;
`ifdef WB_RESP_TXN_CNT_EN
            6'd4: reg_rd = {txn_r_q, txn_w_q};
`endif
            default: reg_rd = 32'hDEAD_BEEF;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            reg_rd_q <= 32'd0;
            rd_ram_q <= 1'b0;
        end else if (commit) begin
            reg_rd_q <= reg_rd;
            rd_ram_q <= is_ram;
        end
    end

    assign wbs.wbs_ack_o = (state_q == ST_ACK);
    assign wbs.wbs_dat_o = (state_q != ST_ACK) ? 32'd0 : (rd_ram_q ? ram_rd : reg_rd_q);

    assign io_out = {status_q[7:6], 10'd0, status_q[5:0], 20'd0};
    assign io_oeb = {2'b00, {10{1'b1}}, 6'b00_0000, {20{1'b1}}};

endmodule

// File: tb/tb_wb_test_responder.sv
// Randomized bench for wb_test_responder: two instances (0 and 3 wait states) checked
// every cycle against a register-map model, plus literal checks for the documented scenarios.
module tb_wb_test_responder;

    localparam int WS0 = 0;
    localparam int WS1 = 3;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [37:0] OEB_EXP = {2'b00, {10{1'b1}}, 6'b00_0000, {20{1'b1}}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int   cycle = 0;
    int   tests = 0;
    int   fails = 0;

    logic        rst_v  [2] = '{1'b1, 1'b1};
    logic        rst_at_edge [2] = '{1'b1, 1'b1};
    logic        stb_v  [2] = '{1'b0, 1'b0};
    logic        cyc_v  [2] = '{1'b0, 1'b0};
    logic        we_v   [2] = '{1'b0, 1'b0};
    logic [3:0]  sel_v  [2] = '{4'h0, 4'h0};
    logic [31:0] adr_v  [2] = '{32'h0, 32'h0};
    logic [31:0] wdat_v [2] = '{32'h0, 32'h0};
    int          exp_ack_cycle [2] = '{-1, -1};

    logic        ack_w  [2];
    logic [31:0] rdat_w [2];
    logic [37:0] io_w   [2];
    logic [37:0] oeb_w  [2];

    wb_test_responder_if bus0 ();
    wb_test_responder_if bus1 ();

    assign bus0.wbs_stb_i = stb_v[0];
    assign bus0.wbs_cyc_i = cyc_v[0];
    assign bus0.wbs_we_i  = we_v[0];
    assign bus0.wbs_sel_i = sel_v[0];
    assign bus0.wbs_adr_i = adr_v[0];
    assign bus0.wbs_dat_i = wdat_v[0];
    assign bus1.wbs_stb_i = stb_v[1];
    assign bus1.wbs_cyc_i = cyc_v[1];
    assign bus1.wbs_we_i  = we_v[1];
    assign bus1.wbs_sel_i = sel_v[1];
    assign bus1.wbs_adr_i = adr_v[1];
    assign bus1.wbs_dat_i = wdat_v[1];
    assign ack_w[0]  = bus0.wbs_ack_o;
    assign ack_w[1]  = bus1.wbs_ack_o;
    assign rdat_w[0] = bus0.wbs_dat_o;
    assign rdat_w[1] = bus1.wbs_dat_o;

    wb_test_responder #(.WAIT_STATES(WS0)) u_dut0 (
        .wb_clk_i (clk),
        .wb_rst_i (rst_v[0]),
        .wbs      (bus0),
        .io_out   (io_w[0]),
        .io_oeb   (oeb_w[0])
    );

    wb_test_responder #(.WAIT_STATES(WS1)) u_dut1 (
        .wb_clk_i (clk),
        .wb_rst_i (rst_v[1]),
        .wbs      (bus1),
        .io_out   (io_w[1]),
        .io_oeb   (oeb_w[1])
    );

    always @(posedge clk) begin
        cycle          <= cycle + 1;
        rst_at_edge[0] <= rst_v[0];
        rst_at_edge[1] <= rst_v[1];
    end

    // Register-map model: COUNT is derived from the edge number of its last reset/clear.
    logic [7:0]  m_status  [2];
    logic [31:0] m_scratch [2];
    logic [31:0] m_ram     [2][16];
    int          m_base    [2];
    int          m_txn_w   [2];
    int          m_txn_r   [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cycle);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
        return merge_ret(r);
    endfunction

    function automatic logic [31:0] merge_ret(input logic [31:0] v);
        return v;
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] adr);
        int w;
        w = int'(adr[7:2]);
        if (w >= 16 && w < 32) return m_ram[d][w - 16];
        case (w)
            0: return 32'hCA5E_0001;
            1: return {24'd0, m_status[d]};
            2: return m_scratch[d];
            3: return 32'(cycle - 1 - m_base[d]);
`ifdef WB_RESP_TXN_CNT_EN
            4: return {m_txn_r[d][15:0], m_txn_w[d][15:0]};
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic model_commit(input int d);
        int w;
        w = int'(adr_v[d][7:2]);
        if (we_v[d]) begin
            if (w == 1 && sel_v[d][0]) m_status[d] = wdat_v[d][7:0];
            if (w == 2) m_scratch[d] = merge(m_scratch[d], wdat_v[d], sel_v[d]);
            if (w == 3) m_base[d] = cycle;
            if (w >= 16 && w < 32) m_ram[d][w - 16] = merge(m_ram[d][w - 16], wdat_v[d], sel_v[d]);
        end
`ifdef WB_RESP_TXN_CNT_EN
        if (we_v[d] && w == 4) begin
            m_txn_w[d] = 0;
            m_txn_r[d] = 0;
        end else if (we_v[d]) begin
            if (m_txn_w[d] < 65535) m_txn_w[d]++;
        end else begin
            if (m_txn_r[d] < 65535) m_txn_r[d]++;
        end
`endif
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic exp_ack;
            if (rst_at_edge[d]) begin
                m_status[d]  = 8'd0;
                m_scratch[d] = 32'd0;
                m_base[d]    = cycle;
                m_txn_w[d]   = 0;
                m_txn_r[d]   = 0;
                check($sformatf("rst_ack[%0d]", d), 64'(ack_w[d]), 64'd0);
                check($sformatf("rst_dat[%0d]", d), 64'(rdat_w[d]), 64'd0);
            end else begin
                exp_ack = (exp_ack_cycle[d] == cycle);
                check($sformatf("ack[%0d]", d), 64'(ack_w[d]), 64'(exp_ack));
                if (exp_ack) begin
                    if (!we_v[d])
                        check($sformatf("rdata[%0d]@%h", d, adr_v[d]), 64'(rdat_w[d]),
                              64'(model_read(d, adr_v[d])));
                    model_commit(d);
                end else begin
                    check($sformatf("idle_dat[%0d]", d), 64'(rdat_w[d]), 64'd0);
                end
            end
            check($sformatf("io_out[%0d]", d), 64'(io_w[d]),
                  64'({m_status[d][7:6], 10'd0, m_status[d][5:0], 20'd0}));
            check($sformatf("io_oeb[%0d]", d), 64'(oeb_w[d]), 64'(OEB_EXP));
        end
    end

    // mode 0: complete normally; 1: drop stb after k cycles; 2: assert reset after k cycles.
    task automatic txn(input int d, input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                       input logic [3:0] sel, input int mode, input int k,
                       output int lat, output logic [31:0] rdata);
        int ws;
        int budget;
        logic hit;
        ws  = (d == 0) ? WS0 : WS1;
        hit = (adr[31:8] == BASE[31:8]);
        @(posedge clk); #1;
        adr_v[d]  = adr;
        wdat_v[d] = wdat;
        sel_v[d]  = sel;
        we_v[d]   = we;
        cyc_v[d]  = 1'b1;
        stb_v[d]  = 1'b1;
        exp_ack_cycle[d] = (hit && mode == 0) ? cycle + 1 + ws : -1;
        lat    = -1;
        rdata  = 32'd0;
        budget = (mode == 0) ? ws + 4 : k;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (ack_w[d]) begin
                lat   = i;
                rdata = rdat_w[d];
                break;
            end
        end
        if (mode == 2) rst_v[d] = 1'b1;
        stb_v[d] = 1'b0;
        cyc_v[d] = 1'b0;
        if (mode == 2) begin
            repeat (2) begin @(posedge clk); #1; end
            rst_v[d] = 1'b0;
        end
    endtask

    task automatic do_reset(input int d);
        @(posedge clk); #1;
        rst_v[d] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst_v[d] = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        repeat (3) begin @(posedge clk); #1; end
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                txn(d, 1'b1, BASE + 32'h40 + 32'(4 * i), $urandom, 4'hF, 0, 0, lat, rd);

        txn(0, 1'b0, BASE, 32'd0, 4'hF, 0, 0, lat, rd);
        check("id_latency", 64'(lat), 64'd1);
        check("id_value", 64'(rd), 64'hCA5E_0001);

        txn(0, 1'b1, BASE + 32'h4, 32'h0000_0041, 4'hF, 0, 0, lat, rd);
        check("pad_phase", 64'(io_w[0][25:20]), 64'd1);
        check("pad_done", 64'(io_w[0][37:36]), 64'd1);
        check("oeb_phase", 64'(oeb_w[0][25:20]), 64'd0);
        check("oeb_done", 64'(oeb_w[0][37:36]), 64'd0);
        check("oeb_19", 64'(oeb_w[0][19]), 64'd1);

        txn(0, 1'b1, BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, 0, 0, lat, rd);
        txn(0, 1'b1, BASE + 32'h8, 32'h1234_5678, 4'b0101, 0, 0, lat, rd);
        txn(0, 1'b0, BASE + 32'h8, 32'd0, 4'hF, 0, 0, lat, rd);
        check("scratch_bytes", 64'(rd), 64'hFF34_FF78);
        txn(0, 1'b1, BASE + 32'h7C, 32'hA5A5_5A5A, 4'hF, 0, 0, lat, rd);
        txn(0, 1'b0, BASE + 32'h7C, 32'd0, 4'hF, 0, 0, lat, rd);
        check("ram15", 64'(rd), 64'hA5A5_5A5A);

        txn(1, 1'b0, BASE + 32'hC, 32'd0, 4'hF, 0, 0, lat, rd);
        check("ws3_latency", 64'(lat), 64'd4);
        txn(1, 1'b1, BASE + 32'h8, 32'h1111_2222, 4'hF, 0, 0, lat, rd);
        txn(1, 1'b1, BASE + 32'h8, 32'hDEAD_0000, 4'hF, 1, 2, lat, rd);
        check("abort_no_ack", 64'(lat == -1), 64'd1);
        txn(1, 1'b0, BASE + 32'h8, 32'd0, 4'hF, 0, 0, lat, rd);
        check("abort_scratch", 64'(rd), 64'h1111_2222);

        txn(0, 1'b0, BASE + 32'h20, 32'd0, 4'hF, 0, 0, lat, rd);
        check("unmapped_ack", 64'(lat), 64'd1);
        check("unmapped_val", 64'(rd), 64'hDEAD_BEEF);
        txn(0, 1'b1, BASE + 32'hC, 32'h5555_5555, 4'hF, 0, 0, lat, rd);
        txn(0, 1'b0, BASE + 32'hC, 32'd0, 4'hF, 0, 0, lat, rd);
        check("count_cleared", 64'(rd < 32'd10), 64'd1);

        txn(1, 1'b1, BASE + 32'h4, 32'h0000_00FF, 4'hF, 0, 0, lat, rd);
        txn(1, 1'b1, BASE + 32'h4, 32'h0000_0012, 4'hF, 2, 2, lat, rd);
        check("rst_wait_no_ack", 64'(lat == -1), 64'd1);
        txn(1, 1'b0, BASE + 32'h4, 32'd0, 4'hF, 0, 0, lat, rd);
        check("rst_wait_status", 64'(rd), 64'd0);

        txn(0, 1'b0, 32'h3000_0100, 32'd0, 4'hF, 0, 0, lat, rd);
        check("outside_no_ack", 64'(lat == -1), 64'd1);

`ifdef WB_RESP_TXN_CNT_EN
        do_reset(1);
        for (int i = 0; i < 3; i++)
            txn(1, 1'b1, BASE + 32'h8, 32'(i), 4'hF, 0, 0, lat, rd);
        for (int i = 0; i < 2; i++)
            txn(1, 1'b0, BASE, 32'd0, 4'hF, 0, 0, lat, rd);
        txn(1, 1'b1, BASE + 32'h8, 32'hFFFF_0000, 4'hF, 1, 1, lat, rd);
        txn(1, 1'b0, BASE + 32'h10, 32'd0, 4'hF, 0, 0, lat, rd);
        check("txn_counts", 64'(rd), 64'h0002_0003);
        txn(1, 1'b1, BASE + 32'h10, 32'd0, 4'hF, 0, 0, lat, rd);
        txn(1, 1'b0, BASE + 32'h10, 32'd0, 4'hF, 0, 0, lat, rd);
        check("txn_cleared", 64'(rd), 64'd0);
`else
        txn(1, 1'b0, BASE + 32'h10, 32'd0, 4'hF, 0, 0, lat, rd);
        check("txn_unmapped", 64'(rd), 64'hDEAD_BEEF);
`endif

        for (int n = 0; n < 240; n++) begin
            int          d;
            int          r;
            int          w;
            int          mode;
            int          k;
            logic [31:0] adr;
            d    = n % 2;
            r    = int'($urandom_range(0, 99));
            w    = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 63));
            adr  = BASE + 32'(w * 4);
            mode = 0;
            k    = 0;
            if (d == 1 && r < 12) begin
                mode = 1;
                k    = int'($urandom_range(1, WS1));
            end else if (r < 18) begin
                adr = BASE ^ (32'h100 << $urandom_range(0, 23));
            end
            txn(d, 1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(0, 15)),
                mode, k, lat, rd);
        end

        repeat (3) begin @(posedge clk); #1; end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_test_responder.md
Name: wb_test_responder

Overview:
- Wishbone classic slave in the user project area; the responder end of the management-SoC Wishbone test firmware.
- Provides an ID register, a status register driven onto mprj_io, a scratch register, a cycle counter and a 16-word scratch RAM.
- Status bits appear on io_out[25:20] (phase) and io_out[37:36] (done code) so the chip-level bench can track test progress from the pads.

Parameters:
- BASE_ADR, 32'h3000_0000, block base; the block decodes adr[31:8] == BASE_ADR[31:8].
- ID_VALUE, 32'hCA5E_0001, value returned by the ID register.
- WAIT_STATES, 0, extra cycles inserted before ack (0..15).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  cycle valid.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte-lane enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- io_out  out  38  pad outputs.
- io_oeb  out  38  pad output enables, active-low.

Behaviour:
- Clocking and reset: one clock, wb_clk_i. Reset is synchronous and active-high on wb_rst_i.
- Reset values: ack=0, dat_o=0, STATUS=0, SCRATCH=0, COUNT=0, FSM=IDLE. RAM contents are undefined.
- Register map (offset from BASE_ADR):
  - 0x00 ID, read-only, returns ID_VALUE.
  - 0x04 STATUS, read/write, bits [7:0] used, [31:8] read 0.
  - 0x08 SCRATCH, read/write.
  - 0x0C COUNT, read-only; any write clears it to 0.
  - 0x40-0x7C RAM[0..15], read/write.
  - Any other offset inside the 256-byte window: reads return 32'hDEAD_BEEF, writes are ignored, ack is still given.
  - Addresses outside the window: no ack (the bus never hangs on this block for in-window accesses).
- Byte lanes: writes to STATUS, SCRATCH and RAM update only the bytes with sel[i]=1. sel=0 still acks and writes nothing.
- FSM: IDLE -> WAIT -> ACK -> IDLE.
  - IDLE: stb&cyc&hit sampled high: if WAIT_STATES=0 go to ACK, else go to WAIT and load the wait counter with WAIT_STATES-1.
  - WAIT: count down to 0, then go to ACK. If stb or cyc drops, return to IDLE with no ack and no write (abort).
  - ACK: ack=1 for exactly one cycle, then always IDLE.
  - A new request is sampled only in IDLE, so a held stb gives back-to-back transactions with at least one idle cycle between acks.
- Latency: ack rises WAIT_STATES+1 cycles after the edge where the request is sampled.
- Write commit: on the same edge that raises ack.
- Read data: dat_o is valid only while ack=1 and is 0 otherwise.
- COUNT: increments every cycle and wraps 0xFFFF_FFFF -> 0. A write-clear wins over the increment in that cycle.
- Pad mapping:
  - io_out[25:20] = STATUS[5:0].
  - io_out[37:36] = STATUS[7:6].
  - All other io_out bits = 0.
  - io_oeb = 0 on bits 37:36 and 25:20, 1 on all other bits.
- Reset asserted mid-transaction: FSM returns to IDLE, no ack, pending write dropped.

Optional Feature:
- Macro: WB_RESP_TXN_CNT_EN.
- Defined:
  - Register 0x10 TXN, read-only: [15:0] = completed writes, [31:16] = completed reads.
  - Counts increment on the acked transaction only; aborted transactions are not counted.
  - Each field saturates at 0xFFFF.
  - Any write to 0x10 clears both fields. That write is itself not counted.
- Not defined: 0x10 behaves as unmapped, reading 32'hDEAD_BEEF.

Test Plan:
- Read 0x3000_0000 after reset -> ack one cycle after request, dat_o=32'hCA5E_0001.
- Write 0x3000_0004 with 0x0000_0041, sel=4'hF -> io_out[25:20]=6'd1, io_out[37:36]=2'b01 on the ack edge; io_oeb[25:20]=0, io_oeb[37:36]=0, io_oeb[19]=1.
- Write SCRATCH 0xFFFF_FFFF, then write 0x1234_5678 with sel=4'b0101 -> read back 0xFF34_FF78. Write RAM[15] (0x3000_007C) 0xA5A5_5A5A -> read back identical.
- WAIT_STATES=3, read COUNT -> ack exactly 4 cycles after request. Drop stb after 2 cycles of a write to SCRATCH -> no ack, SCRATCH unchanged.
- Read 0x3000_0020 -> ack, dat_o=32'hDEAD_BEEF. Write COUNT -> next read returns a value below 10. Assert reset during WAIT -> no ack, STATUS=0.
- With WB_RESP_TXN_CNT_EN: 3 writes, 2 reads, 1 aborted write, then read 0x10 -> 32'h0002_0003. Write 0x10, then read 0x10 -> 32'h0000_0000.
